gpio_irq: RTL and testbench
===========================

Name: gpio_irq

Overview:
- Next-generation CSR-mapped GPIO block that sits on the csrbrg CSR bus alongside uart and sysctl.
- Adds over the current gpio:
  - parametrised pin count;
  - per-pin output enable;
  - synchronised inputs;
  - atomic set/clear/toggle of outputs;
  - rising/falling edge detection with a sticky pending register, mask and a level interrupt line for lm32.
- Its read data is OR-combined into csrbrg csr_di, so it drives zero when not selected.

Parameters:
- csr_addr, 4'h0, CSR bank select; compared against csr_a[13:10].
- WIDTH, 32, number of GPIO pins (1..32). Unused upper read bits return 0.
- SYNC_STAGES, 2, input synchroniser depth (2..4).
- OUT_RESET, 0, reset value of OUT register ([WIDTH-1:0]).

Ports:
- sys_clk  in  1  system clock; all logic on rising edge.
- sys_rst  in  1  synchronous active-high reset.
- csr_a  in  14  CSR address: [13:10] bank, [3:0] register index.
- csr_we  in  1  CSR write strobe, single cycle.
- csr_di  in  32  CSR write data.
- csr_do  out  32  CSR read data, registered, 0 when bank not selected.
- gpio_in  in  WIDTH  asynchronous pin inputs.
- gpio_out  out  WIDTH  output data (OUT register).
- gpio_oe  out  WIDTH  output enables, 1 = drive.
- irq  out  1  level interrupt, registered.

Behaviour:
- Selection: sel = (csr_a[13:10] == csr_addr). Only csr_a[3:0] is decoded; indices 10..15 read 0 and ignore writes.
- Registers (index: name, access):
  - 0 IN, RO: synchronised gpio_in.
  - 1 OUT, RW.
  - 2 OE, RW.
  - 3 RISE_EN, RW.
  - 4 FALL_EN, RW.
  - 5 PENDING, RW1C.
  - 6 MASK, RW.
  - 7 OUT_SET, WO: OUT |= di.
  - 8 OUT_CLR, WO: OUT &= ~di.
  - 9 OUT_TGL, WO: OUT ^= di.
  - Write-only registers read 0.
- Read timing:
  - csr_do is updated every cycle: the selected register value if sel, else 32'h0.
  - Latency is 1 cycle from csr_a to csr_do. A read of the cycle immediately after a write returns the new value.
- Write timing: writes take effect on the sys_clk edge with csr_we & sel. gpio_out and gpio_oe are direct register outputs (1-cycle latency from write).
- Input path:
  - Each pin passes through a SYNC_STAGES flop chain, then one "prev" flop.
  - rise = sync & ~prev; fall = ~sync & prev.
- Pending register:
  - Next value: PENDING_next = (PENDING & ~w1c) | (rise & RISE_EN) | (fall & FALL_EN).
  - w1c = di masked to WIDTH when writing index 5, otherwise 0.
  - Simultaneous edge and W1C on the same bit: set wins, so the bit stays 1.
- Interrupt: irq <= |(PENDING & MASK), registered. irq therefore asserts 1 cycle after PENDING sets and deasserts 1 cycle after PENDING clears or MASK clears.
- Edge-to-irq latency: SYNC_STAGES+2 cycles from gpio_in change (default 4).
- Reset (sys_rst=1, synchronous, overrides any simultaneous write):
  - OUT=OUT_RESET; all other registers (OE, RISE_EN, FALL_EN, PENDING, MASK) = 0.
  - Sync chain and prev flops = 0.
  - csr_do=0, irq=0.
  - A pin already high at reset produces an internal rise pulse after release. It is harmless because RISE_EN=0.
- Bits above WIDTH: ignored on write, read as 0.
- Pin glitches shorter than one sys_clk period may be missed; no pulse stretching is performed.

Decomposition:
- Package gpio_irq_pkg holds:
  - register index constants (REG_IN=0 … REG_OUT_TGL=9);
  - the 4-bit bank field position constants.
- One sub-module, gpio_irq_sync (parameters WIDTH, SYNC_STAGES):
  - contains the synchroniser chain plus prev flop;
  - outputs sync, rise and fall vectors.
- Everything else (decode, registers, read mux, irq) stays in gpio_irq.

Test Plan:
- Reset/read-back: csr_addr=4'h1, WIDTH=8. Assert sys_rst, then read each index 0..9 at csr_a=14'h0400|idx → csr_do=0; gpio_out=0, gpio_oe=0, irq=0.
- Atomic output ops:
  - write OUT=0xA5 → gpio_out=0xA5 next cycle;
  - OUT_SET 0x0F → 0xAF;
  - OUT_CLR 0xA0 → 0x0F;
  - OUT_TGL 0xFF → 0xF0;
  - read index 1 → 0xF0;
  - read index 7 → 0;
  - write 0xFFFFFFFF to OUT → read 0x000000FF.
- Bank isolation: csr_a=14'h0801 with csr_we, di=0x55 → gpio_out unchanged and csr_do=0 the following cycle.
- Rising edge irq:
  - RISE_EN=0x01, MASK=0x01, raise gpio_in[0] → irq=1 exactly 4 cycles later;
  - PENDING reads 0x01;
  - W1C 0x01 → irq=0 two cycles later (PENDING clears on the write edge, irq one cycle after).
  - Falling edge with FALL_EN=0 → no pending.
- Set-wins collision: RISE_EN=0x02, MASK=0x02. Time gpio_in[1] 0→1 so rise is high in the same cycle as the W1C 0x02 write → PENDING[1] stays 1 and irq stays 1.
- Reset mid-operation: with PENDING=0x03, irq=1, OUT=0x3C, assert sys_rst for 1 cycle concurrent with a csr write of OUT=0xFF → OUT=OUT_RESET, PENDING=0, irq=0; the write is discarded.

Source files
------------

// File: rtl/gpio_irq_pkg.sv
// gpio_irq_pkg: register indices and bank field position for the gpio_irq CSR block
package gpio_irq_pkg;
  localparam logic [3:0] REG_IN      = 4'd0;
  localparam logic [3:0] REG_OUT     = 4'd1;
  localparam logic [3:0] REG_OE      = 4'd2;
  localparam logic [3:0] REG_RISE_EN = 4'd3;
  localparam logic [3:0] REG_FALL_EN = 4'd4;
  localparam logic [3:0] REG_PENDING = 4'd5;
  localparam logic [3:0] REG_MASK    = 4'd6;
  localparam logic [3:0] REG_OUT_SET = 4'd7;
  localparam logic [3:0] REG_OUT_CLR = 4'd8;
  localparam logic [3:0] REG_OUT_TGL = 4'd9;
  localparam int BANK_LSB = 10;
  localparam int BANK_MSB = 13;
endpackage

// File: rtl/gpio_irq_sync.sv
// gpio_irq_sync: input synchroniser chain plus previous-value flop producing edge pulses
module gpio_irq_sync #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] chain;
  logic [WIDTH-1:0] prev;
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
      prev  <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      prev  <= chain[SYNC_STAGES-1];
    end
  end
  assign sync = chain[SYNC_STAGES-1];
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;
endmodule

// File: rtl/gpio_irq.sv
// gpio_irq: CSR-mapped GPIO with output enables, atomic output ops and edge interrupts
module gpio_irq
  import gpio_irq_pkg::*;
#(
  parameter logic [3:0]       csr_addr    = 4'h0,
  parameter int               WIDTH       = 32,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] OUT_RESET   = '0
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [13:0]      csr_a,
  input  logic             csr_we,
  input  logic [31:0]      csr_di,
  output logic [31:0]      csr_do,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);
  logic             sel, wr;
  logic [3:0]       idx;
  logic [WIDTH-1:0] wd, sync, rise, fall, rise_en, fall_en, pending, mask;
  logic [WIDTH-1:0] out_next, w1c, rdata;
  logic             unused;
  assign sel    = csr_a[BANK_MSB:BANK_LSB] == csr_addr;
  assign idx    = csr_a[3:0];
  assign wr     = csr_we & sel;
  assign wd     = csr_di[WIDTH-1:0];
  assign unused = ^{csr_a[BANK_LSB-1:4], csr_di >> WIDTH};
  gpio_irq_sync #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk (sys_clk),
    .rst (sys_rst),
    .din (gpio_in),
    .sync(sync),
    .rise(rise),
    .fall(fall)
  );
  always_comb begin
    out_next = !wr                ? gpio_out :
               idx == REG_OUT     ? wd :
               idx == REG_OUT_SET ? gpio_out | wd :
               idx == REG_OUT_CLR ? gpio_out & ~wd :
               idx == REG_OUT_TGL ? gpio_out ^ wd : gpio_out;
    w1c = (wr && idx == REG_PENDING) ? wd : '0;
  end
  always_comb begin
    rdata = '0;
    case (idx)
      REG_IN:      rdata = sync;
      REG_OUT:     rdata = gpio_out;
      REG_OE:      rdata = gpio_oe;
      REG_RISE_EN: rdata = rise_en;
      REG_FALL_EN: rdata = fall_en;
      REG_PENDING: rdata = pending;
      REG_MASK:    rdata = mask;
      default:     rdata = '0;
    endcase
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      gpio_out <= OUT_RESET;
      gpio_oe  <= '0;
      rise_en  <= '0;
      fall_en  <= '0;
      pending  <= '0;
      mask     <= '0;
      irq      <= 1'b0;
      csr_do   <= '0;
    end else begin
      gpio_out <= out_next;
      if (wr && idx == REG_OE) gpio_oe <= wd;
      if (wr && idx == REG_RISE_EN) rise_en <= wd;
      if (wr && idx == REG_FALL_EN) fall_en <= wd;
      if (wr && idx == REG_MASK) mask <= wd;
      pending <= (pending & ~w1c) | (rise & rise_en) | (fall & fall_en);
      irq     <= |(pending & mask);
      csr_do  <= sel ? 32'(rdata) : 32'h0;
    end
  end
endmodule

// File: tb/tb_gpio_irq.sv
// tb_gpio_irq: directed self-checking bench for gpio_irq with bank 1 and 8 pins
module tb_gpio_irq;
  logic        sys_clk, sys_rst, csr_we, irq;
  logic [13:0] csr_a;
  logic [31:0] csr_di, csr_do, d;
  logic [7:0]  gpio_in, gpio_out, gpio_oe;
  int          checks, failures;
  gpio_irq #(.csr_addr(4'h1), .WIDTH(8), .SYNC_STAGES(2), .OUT_RESET(8'h00)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .csr_a   (csr_a),
    .csr_we  (csr_we),
    .csr_di  (csr_di),
    .csr_do  (csr_do),
    .gpio_in (gpio_in),
    .gpio_out(gpio_out),
    .gpio_oe (gpio_oe),
    .irq     (irq)
  );
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge sys_clk);
      #1;
    end
  endtask
  task automatic wr(input logic [3:0] idx, input logic [31:0] data);
    csr_a  = 14'h0400 | 14'(idx);
    csr_di = data;
    csr_we = 1'b1;
    step(1);
    csr_we = 1'b0;
  endtask
  task automatic rd(input logic [3:0] idx, output logic [31:0] data);
    csr_a  = 14'h0400 | 14'(idx);
    csr_we = 1'b0;
    step(1);
    data = csr_do;
  endtask
  initial begin
    checks = 0;
    failures = 0;
    sys_rst = 1'b1;
    csr_we = 1'b0;
    csr_a = '0;
    csr_di = '0;
    gpio_in = '0;
    step(3);
    chk("rst_out", 32'(gpio_out), 32'h0);
    chk("rst_oe", 32'(gpio_oe), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_do", csr_do, 32'h0);
    sys_rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rd(4'(i), d);
      chk($sformatf("rst_rd%0d", i), d, 32'h0);
    end
    wr(4'd1, 32'hA5);
    chk("out_wr", 32'(gpio_out), 32'hA5);
    wr(4'd7, 32'h0F);
    chk("out_set", 32'(gpio_out), 32'hAF);
    wr(4'd8, 32'hA0);
    chk("out_clr", 32'(gpio_out), 32'h0F);
    wr(4'd9, 32'hFF);
    chk("out_tgl", 32'(gpio_out), 32'hF0);
    rd(4'd1, d);
    chk("rd_out", d, 32'hF0);
    rd(4'd7, d);
    chk("rd_set_wo", d, 32'h0);
    wr(4'd1, 32'hFFFF_FFFF);
    rd(4'd1, d);
    chk("rd_out_wide", d, 32'hFF);
    wr(4'd2, 32'h3C);
    chk("oe_wr", 32'(gpio_oe), 32'h3C);
    rd(4'd2, d);
    chk("rd_oe", d, 32'h3C);
    wr(4'd10, 32'h77);
    rd(4'd10, d);
    chk("rd_idx10", d, 32'h0);
    csr_a = 14'h0801;
    csr_di = 32'h55;
    csr_we = 1'b1;
    step(1);
    csr_we = 1'b0;
    chk("bank_out", 32'(gpio_out), 32'hFF);
    chk("bank_do0", csr_do, 32'h0);
    step(1);
    chk("bank_do1", csr_do, 32'h0);
    gpio_in = 8'h5A;
    step(3);
    rd(4'd0, d);
    chk("rd_in", d, 32'h5A);
    gpio_in = 8'h00;
    step(4);
    wr(4'd3, 32'h01);
    wr(4'd6, 32'h01);
    gpio_in = 8'h01;
    step(3);
    chk("rise_irq_early", 32'(irq), 32'h0);
    step(1);
    chk("rise_irq", 32'(irq), 32'h1);
    rd(4'd5, d);
    chk("rise_pend", d, 32'h01);
    wr(4'd5, 32'h01);
    chk("w1c_irq_hold", 32'(irq), 32'h1);
    step(1);
    chk("w1c_irq_clr", 32'(irq), 32'h0);
    rd(4'd5, d);
    chk("w1c_pend", d, 32'h0);
    gpio_in = 8'h00;
    step(5);
    rd(4'd5, d);
    chk("fall_dis_pend", d, 32'h0);
    chk("fall_dis_irq", 32'(irq), 32'h0);
    wr(4'd3, 32'h02);
    wr(4'd6, 32'h02);
    gpio_in = 8'h02;
    step(4);
    gpio_in = 8'h00;
    step(4);
    chk("coll_pre_irq", 32'(irq), 32'h1);
    gpio_in = 8'h02;
    step(2);
    wr(4'd5, 32'h02);
    rd(4'd5, d);
    chk("coll_pend", d, 32'h02);
    chk("coll_irq", 32'(irq), 32'h1);
    wr(4'd5, 32'h02);
    rd(4'd5, d);
    chk("coll_after_w1c", d, 32'h0);
    gpio_in = 8'h00;
    step(4);
    wr(4'd3, 32'h03);
    wr(4'd6, 32'h03);
    gpio_in = 8'h03;
    step(4);
    wr(4'd1, 32'h3C);
    rd(4'd5, d);
    chk("mid_pend", d, 32'h03);
    chk("mid_irq", 32'(irq), 32'h1);
    chk("mid_out", 32'(gpio_out), 32'h3C);
    csr_a = 14'h0401;
    csr_di = 32'hFF;
    csr_we = 1'b1;
    sys_rst = 1'b1;
    step(1);
    sys_rst = 1'b0;
    csr_we = 1'b0;
    chk("mid_rst_out", 32'(gpio_out), 32'h0);
    chk("mid_rst_irq", 32'(irq), 32'h0);
    chk("mid_rst_do", csr_do, 32'h0);
    rd(4'd5, d);
    chk("mid_rst_pend", d, 32'h0);
    rd(4'd2, d);
    chk("mid_rst_oe", d, 32'h0);
    step(4);
    chk("mid_rst_irq_late", 32'(irq), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
